// File: rtl/piso_pkg.sv
`default_nettype none
// ============================================================================
// Module      : piso_pkg
// Description : Shared state encoding, bit-order constants and counter sizing
//               for the PISO transmitter and its beat counter.
// Revision    : 1.0 - initial release
// ============================================================================
package piso_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_PAR   = 2'd2;

    localparam int BIT_ORDER_LSB = 0;
    localparam int BIT_ORDER_MSB = 1;

    // Wide enough to hold every beat index of a WIDTH-bit frame.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/piso_bit_cnt.sv
`default_nettype none
// ============================================================================
// Module      : piso_bit_cnt
// Description : Loadable beat counter that saturates at LAST and flags it.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_bit_cnt #(
    parameter int CNT_W = 3,
    parameter int LAST  = 3
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(LAST));

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= '0;
        end else if (inc && !w_last) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt  = r_cnt;
    assign last = w_last;

endmodule
`default_nettype wire

// File: rtl/piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : piso_tx
// Description : Parallel-in/serial-out transmitter with first/last framing,
//               gapless back-to-back frames. Optional even-parity beat when
//               PISO_TX_PARITY_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_tx
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             so,
    output logic             so_valid,
    output logic             so_first,
    output logic             so_last
);

    localparam int c_CW = cnt_width(WIDTH);

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_sreg;
    logic             r_so;
    logic             r_so_valid;
    logic             r_so_first;
    logic             r_so_last;

    logic [c_CW-1:0]  w_cnt;
    logic             w_cnt_last;
    logic             w_final;
    logic             w_accept;
    logic             w_next_last;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_load_rest;
    logic [WIDTH-1:0] w_shift_rest;

    // The register holds only the bits not yet presented, aligned so the
    // next bit to send is always at the shifting end.
    generate
        if (MSB_FIRST == BIT_ORDER_MSB) begin : g_msb
            assign w_first_bit  = din[WIDTH-1];
            assign w_load_rest  = {din[WIDTH-2:0], 1'b0};
            assign w_next_bit   = r_sreg[WIDTH-1];
            assign w_shift_rest = {r_sreg[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign w_first_bit  = din[0];
            assign w_load_rest  = {1'b0, din[WIDTH-1:1]};
            assign w_next_bit   = r_sreg[0];
            assign w_shift_rest = {1'b0, r_sreg[WIDTH-1:1]};
        end
    endgenerate

    piso_bit_cnt #(
        .CNT_W (c_CW),
        .LAST  (WIDTH - 1)
    ) u_bit_cnt (
        .clk  (clk),
        .clr  (clr),
        .load (w_accept),
        .inc  ((r_state == ST_SHIFT) && !w_accept),
        .cnt  (w_cnt),
        .last (w_cnt_last)
    );

`ifdef PISO_TX_PARITY_EN
    logic r_par;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_par <= 1'b0;
        end else if (w_accept) begin
            r_par <= ^din;
        end
    end

    assign w_final     = (r_state == ST_PAR);
    assign w_next_last = 1'b0;
`else
    assign w_final     = (r_state == ST_SHIFT) && w_cnt_last;
    assign w_next_last = (w_cnt == c_CW'(WIDTH - 2));
`endif

    assign din_ready = !clr && ((r_state == ST_IDLE) || w_final);
    assign w_accept  = din_valid && din_ready;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state    <= ST_IDLE;
            r_sreg     <= '0;
            r_so       <= 1'b0;
            r_so_valid <= 1'b0;
            r_so_first <= 1'b0;
            r_so_last  <= 1'b0;
        end else if (w_accept) begin
            // Loading always wins, which is what makes the final beat
            // hand over to beat 0 of the next frame without a bubble.
            r_state    <= ST_SHIFT;
            r_sreg     <= w_load_rest;
            r_so       <= w_first_bit;
            r_so_valid <= 1'b1;
            r_so_first <= 1'b1;
            r_so_last  <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (w_cnt_last) begin
`ifdef PISO_TX_PARITY_EN
                        r_state    <= ST_PAR;
                        r_so       <= r_par;
                        r_so_valid <= 1'b1;
                        r_so_first <= 1'b0;
                        r_so_last  <= 1'b1;
`else
                        r_state    <= ST_IDLE;
                        r_so       <= 1'b0;
                        r_so_valid <= 1'b0;
                        r_so_first <= 1'b0;
                        r_so_last  <= 1'b0;
`endif
                    end else begin
                        r_sreg     <= w_shift_rest;
                        r_so       <= w_next_bit;
                        r_so_valid <= 1'b1;
                        r_so_first <= 1'b0;
                        r_so_last  <= w_next_last;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_so       <= 1'b0;
                    r_so_valid <= 1'b0;
                    r_so_first <= 1'b0;
                    r_so_last  <= 1'b0;
                end
            endcase
        end
    end

    assign so       = r_so;
    assign so_valid = r_so_valid;
    assign so_first = r_so_first;
    assign so_last  = r_so_last;

endmodule
`default_nettype wire

// File: tb/tb_piso_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_tx
// Description : Self-checking bench for piso_tx; three configurations driven
//               together against a queue-of-beats reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_tx;

`ifdef PISO_TX_PARITY_EN
    localparam int c_PB = 1;
`else
    localparam int c_PB = 0;
`endif

    typedef struct packed {
        logic b;
        logic f;
        logic l;
    } beat_t;

    logic       clk;
    logic       clr;
    logic       din_valid;
    logic [3:0] din4;
    logic [7:0] din8;

    logic rdy0, so0, sv0, sf0, sl0;
    logic rdy1, so1, sv1, sf1, sl1;
    logic rdy2, so2, sv2, sf2, sl2;

    int n_checks;
    int n_errors;

    beat_t q0[$];
    beat_t q1[$];
    beat_t q2[$];

    piso_tx #(.WIDTH(4), .MSB_FIRST(0)) u_dut0 (
        .clk(clk), .clr(clr), .din(din4), .din_valid(din_valid), .din_ready(rdy0),
        .so(so0), .so_valid(sv0), .so_first(sf0), .so_last(sl0)
    );

    piso_tx #(.WIDTH(4), .MSB_FIRST(1)) u_dut1 (
        .clk(clk), .clr(clr), .din(din4), .din_valid(din_valid), .din_ready(rdy1),
        .so(so1), .so_valid(sv1), .so_first(sf1), .so_last(sl1)
    );

    piso_tx #(.WIDTH(8), .MSB_FIRST(0)) u_dut2 (
        .clk(clk), .clr(clr), .din(din8), .din_valid(din_valid), .din_ready(rdy2),
        .so(so2), .so_valid(sv2), .so_first(sf2), .so_last(sl2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Beat k of a frame: data bits in transmit order, then optional parity.
    function automatic beat_t beat_of(input logic [7:0] d, input int w, input bit msb, input int k);
        beat_t r;
        logic  p;
        p = 1'b0;
        for (int i = 0; i < w; i++) p = p ^ d[i];
        if (k < w) r.b = msb ? d[w-1-k] : d[k];
        else       r.b = p;
        r.f = (k == 0);
        r.l = (k == w + c_PB - 1);
        return r;
    endfunction

    task automatic check_dut(input string tag, input logic s, input logic v, input logic f,
                             input logic l, input logic r, input beat_t e, input logic ev,
                             input logic er);
        check({tag, ".so"},        32'(s), 32'(e.b));
        check({tag, ".so_valid"},  32'(v), 32'(ev));
        check({tag, ".so_first"},  32'(f), 32'(e.f));
        check({tag, ".so_last"},   32'(l), 32'(e.l));
        check({tag, ".din_ready"}, 32'(r), 32'(er));
    endtask

    task automatic step(input logic v, input logic [3:0] d4, input logic [7:0] d8, input logic c);
        beat_t e0, e1, e2;
        logic  r0, r1, r2;
        din_valid = v;
        din4      = d4;
        din8      = d8;
        clr       = c;
        if (c) begin
            q0.delete();
            q1.delete();
            q2.delete();
        end
        @(negedge clk);
        e0 = (q0.size() > 0) ? q0[0] : 3'b000;
        e1 = (q1.size() > 0) ? q1[0] : 3'b000;
        e2 = (q2.size() > 0) ? q2[0] : 3'b000;
        // Ready while idle or while the last remaining beat is on the line.
        r0 = !c && (q0.size() <= 1);
        r1 = !c && (q1.size() <= 1);
        r2 = !c && (q2.size() <= 1);
        check_dut("w4lsb", so0, sv0, sf0, sl0, rdy0, e0, q0.size() > 0, r0);
        check_dut("w4msb", so1, sv1, sf1, sl1, rdy1, e1, q1.size() > 0, r1);
        check_dut("w8lsb", so2, sv2, sf2, sl2, rdy2, e2, q2.size() > 0, r2);
        @(posedge clk);
        if (!c) begin
            if (q0.size() > 0) void'(q0.pop_front());
            if (q1.size() > 0) void'(q1.pop_front());
            if (q2.size() > 0) void'(q2.pop_front());
            if (v && r0) for (int k = 0; k < 4 + c_PB; k++) q0.push_back(beat_of({4'b0, d4}, 4, 1'b0, k));
            if (v && r1) for (int k = 0; k < 4 + c_PB; k++) q1.push_back(beat_of({4'b0, d4}, 4, 1'b1, k));
            if (v && r2) for (int k = 0; k < 8 + c_PB; k++) q2.push_back(beat_of(d8, 8, 1'b0, k));
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 4'h0, 8'h00, 1'b0);
    endtask

    initial begin
        clk       = 1'b0;
        clr       = 1'b1;
        din_valid = 1'b0;
        din4      = 4'h0;
        din8      = 8'h00;
        n_checks  = 0;
        n_errors  = 0;

        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 8'h00, 1'b1);

        // Single frame; MSB-first copy sees the same word.
        step(1'b1, 4'b1011, 8'hA5, 1'b0);
        idle(10);

        // Back-to-back with din_valid held across the final beat.
        step(1'b1, 4'b0001, 8'h3C, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 4'b1110, 8'h3C, 1'b0);
        idle(12);

        // Reset in the middle of a frame, then a fresh frame.
        step(1'b1, 4'b1111, 8'hFF, 1'b0);
        step(1'b0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 4'h0, 8'h00, 1'b0);
        step(1'b0, 4'h0, 8'h00, 1'b1);
        step(1'b1, 4'b0101, 8'h5A, 1'b0);
        idle(10);

        // MSB-first boundary word, then din disturbed while in flight.
        step(1'b1, 4'b1000, 8'h81, 1'b0);
        step(1'b0, 4'b0111, 8'h7E, 1'b0);
        step(1'b0, 4'b1111, 8'hFF, 1'b0);
        idle(10);

        for (int i = 0; i < 800; i++) begin
            step(logic'($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
                 logic'($urandom_range(0, 60) == 0));
        end
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
`default_nettype wire
